// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state, and memory arbiter state.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Handshake state reported by the RAM model/controller.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter grant state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2,
        FAULT  = 2'd3
    } arb_state_t;

    // Width of a counter that must reach limit-1 without wrapping.
    function automatic int countWidth(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_wait_timer.sv
// Grant wait counter: counts grant cycles without ACCESS, flags the last allowed one.
// Latency: expired reflects the registered count combinationally.
// Backpressure: saturates at TIMEOUT-1 and holds; clear dominates advance.
module memory_arbiter_wait_timer
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic advance,
    output logic expired
);

    localparam int CW = countWidth(TIMEOUT);

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT - 1));

    // Count waiting grant cycles; cleared outside a grant, never wraps.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with fairness and watchdog.
// Latency: grant one cycle after request; hit pulse one cycle after RAM ACCESS (zero-wait: request n -> hit n+2).
// Backpressure: requesters hold their request until hit; RAM BUSY/FREE stalls the grant up to TIMEOUT cycles.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output word_t     iload,
    output logic      dhit,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      fault
);

    arb_state_t state;
    arb_state_t nextState;

    // Set when the most recent completed access belonged to the data side.
    logic lastGrantData;
    logic lastGrantNext;

    logic dReq;
    logic ihitNext;
    logic dhitNext;
    logic captureI;
    logic captureD;
    logic faultNext;
    logic timerClear;
    logic timerAdvance;
    logic timerExpired;

    assign dReq = dREN | dWEN;

    memory_arbiter_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) uWaitTimer (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (timerClear),
        .advance (timerAdvance),
        .expired (timerExpired)
    );

    // Registered state, hit pulses, load data, sticky fault and fairness flag.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state         <= IDLE;
            ihit          <= 1'b0;
            dhit          <= 1'b0;
            iload         <= '0;
            dload         <= '0;
            fault         <= 1'b0;
            lastGrantData <= 1'b0;
        end else begin
            state         <= nextState;
            ihit          <= ihitNext;
            dhit          <= dhitNext;
            fault         <= faultNext;
            lastGrantData <= lastGrantNext;
            if (captureI) begin
                iload <= ramload;
            end
            if (captureD) begin
                dload <= ramload;
            end
        end
    end

    // Next-state selection and RAM port drive from the current grant.
    always_comb begin
        nextState     = state;
        ramREN        = 1'b0;
        ramWEN        = 1'b0;
        ramaddr       = '0;
        ramstore      = '0;
        ihitNext      = 1'b0;
        dhitNext      = 1'b0;
        captureI      = 1'b0;
        captureD      = 1'b0;
        lastGrantNext = lastGrantData;
        faultNext     = fault;
        timerClear    = 1'b1;
        timerAdvance  = 1'b0;

        case (state)
            IDLE: begin
                // A requester just served is still holding its request this cycle.
                if (!(ihit || dhit)) begin
                    if (dReq && iREN) begin
                        nextState = lastGrantData ? IGRANT : DGRANT;
                    end else if (dReq) begin
                        nextState = DGRANT;
                    end else if (iREN) begin
                        nextState = IGRANT;
                    end
                end
            end

            DGRANT: begin
                ramaddr    = daddr;
                ramstore   = dstore;
                ramWEN     = dWEN;
                ramREN     = dREN & ~dWEN;
                timerClear = 1'b0;
                if (ramstate == ERROR) begin
                    nextState = FAULT;
                    faultNext = 1'b1;
                end else if (!dReq) begin
                    nextState = IDLE;
                end else if (ramstate == ACCESS) begin
                    nextState     = IDLE;
                    dhitNext      = 1'b1;
                    captureD      = ~dWEN;
                    lastGrantNext = 1'b1;
                end else if (timerExpired) begin
                    nextState = FAULT;
                    faultNext = 1'b1;
                end else begin
                    timerAdvance = 1'b1;
                end
            end

            IGRANT: begin
                ramaddr    = iaddr;
                ramREN     = 1'b1;
                timerClear = 1'b0;
                if (ramstate == ERROR) begin
                    nextState = FAULT;
                    faultNext = 1'b1;
                end else if (!iREN) begin
                    nextState = IDLE;
                end else if (ramstate == ACCESS) begin
                    nextState     = IDLE;
                    ihitNext      = 1'b1;
                    captureI      = 1'b1;
                    lastGrantNext = 1'b0;
                end else if (timerExpired) begin
                    nextState = FAULT;
                    faultNext = 1'b1;
                end else begin
                    timerAdvance = 1'b1;
                end
            end

            FAULT: begin
                faultNext = 1'b1;
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios, cycle-level reference model, literal spot checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int TO = 8;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      ihit, dhit, ramREN, ramWEN, fault;
    word_t     iload, dload, ramaddr, ramstore;
    ramstate_t ramstate;
    word_t     ramload;

    // RAM stand-in: either answers every enabled cycle with ACCESS, or follows a forced state.
    logic      autoRam;
    ramstate_t forcedState;
    word_t     forcedLoad;

    assign ramstate = autoRam ? ((ramREN || ramWEN) ? ACCESS : FREE) : forcedState;
    assign ramload  = autoRam ? (ramaddr ^ 32'hA5A5_0000) : forcedLoad;

    always #5 CLK = ~CLK;

    memory_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .fault(fault)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mSide: 0 = nobody owns the RAM, 1 = data side owns it, 2 = instruction side owns it.
    int        mSide = 0;
    int        mWaited = 0;
    bit        mFault = 0, mLastData = 0, mIhit = 0, mDhit = 0, modelOn = 0;
    word_t     mIload = '0, mDload = '0;
    logic      eRen, eWen;
    word_t     eAddr, eStore, mLoad;
    ramstate_t mState;

    always_comb begin
        eRen = 1'b0; eWen = 1'b0; eAddr = '0; eStore = '0;
        if (mSide == 1) begin
            eAddr = daddr; eStore = dstore; eWen = dWEN; eRen = dREN && !dWEN;
        end else if (mSide == 2) begin
            eAddr = iaddr; eRen = 1'b1;
        end
        mState = autoRam ? ((eRen || eWen) ? ACCESS : FREE) : forcedState;
        mLoad  = autoRam ? (eAddr ^ 32'hA5A5_0000) : forcedLoad;
    end

    always @(posedge CLK) begin
        bit hadHit;
        bit req;
        if (!nRST) begin
            modelOn = 1; mSide = 0; mWaited = 0; mFault = 0; mLastData = 0;
            mIhit = 0; mDhit = 0; mIload = '0; mDload = '0;
        end else if (modelOn) begin
            hadHit = mIhit || mDhit;
            mIhit = 0; mDhit = 0;
            if (mFault) begin
                mSide = 0;
            end else if (mSide == 0) begin
                mWaited = 0;
                if (!hadHit) begin
                    if ((dREN || dWEN) && iREN) mSide = mLastData ? 2 : 1;
                    else if (dREN || dWEN)      mSide = 1;
                    else if (iREN)              mSide = 2;
                end
            end else begin
                req = (mSide == 1) ? (dREN || dWEN) : iREN;
                if (mState == ERROR) begin
                    mFault = 1; mSide = 0;
                end else if (!req) begin
                    mSide = 0;
                end else if (mState == ACCESS) begin
                    if (mSide == 1) begin
                        mDhit = 1; mLastData = 1;
                        if (!dWEN) mDload = mLoad;
                    end else begin
                        mIhit = 1; mLastData = 0; mIload = mLoad;
                    end
                    mSide = 0;
                end else if (mWaited + 1 >= TO) begin
                    mFault = 1; mSide = 0;
                end else begin
                    mWaited++;
                end
            end
        end
    end

    // Hit log for the fairness scenario: kind 1 = data, 2 = instruction.
    int cyc = 0;
    int hitKind[$];
    int hitCyc[$];
    always @(posedge CLK) cyc++;

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (modelOn) begin
            check("ramREN",   {31'b0, ramREN}, {31'b0, eRen});
            check("ramWEN",   {31'b0, ramWEN}, {31'b0, eWen});
            check("ramaddr",  ramaddr, eAddr);
            check("ramstore", ramstore, eStore);
            check("ihit",     {31'b0, ihit}, {31'b0, mIhit});
            check("dhit",     {31'b0, dhit}, {31'b0, mDhit});
            check("iload",    iload, mIload);
            check("dload",    dload, mDload);
            check("fault",    {31'b0, fault}, {31'b0, mFault});
            check("hit_overlap", {31'b0, ihit && dhit}, 32'd0);
            if (dhit) begin hitKind.push_back(1); hitCyc.push_back(cyc); end
            if (ihit) begin hitKind.push_back(2); hitCyc.push_back(cyc); end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic resetDut();
        nRST = 1'b0;
        tick(2);
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h4; daddr = 32'h100; dstore = '0;
        autoRam = 1'b0; forcedState = FREE; forcedLoad = '0;

        // Reset with both requests held: quiet outputs, then data wins first.
        tick(2);
        check("rst_ramREN", {31'b0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("rst_hits",   {30'b0, ihit, dhit}, 32'd0);
        check("rst_fault",  {31'b0, fault}, 32'd0);
        check("rst_loads",  iload | dload, 32'd0);
        nRST = 1'b1;
        tick(1);
        check("first_grant_addr", ramaddr, 32'h100);
        check("first_grant_ren",  {31'b0, ramREN}, 32'd1);
        // Dropping the request while granted returns to idle with no hit.
        iREN = 1'b0; dREN = 1'b0;
        tick(1);
        check("drop_ren",  {31'b0, ramREN}, 32'd0);
        tick(1);
        check("drop_dhit", {31'b0, dhit}, 32'd0);

        // Instruction fetch with two BUSY wait states.
        resetDut();
        iREN = 1'b1; iaddr = 32'h4; forcedState = BUSY; forcedLoad = 32'h2408_0001;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("ifetch_ren",  {31'b0, ramREN}, 32'd1);
            check("ifetch_addr", ramaddr, 32'h4);
        end
        forcedState = ACCESS;
        tick(1);
        check("ifetch_ihit",  {31'b0, ihit}, 32'd1);
        check("ifetch_iload", iload, 32'h2408_0001);
        iREN = 1'b0; forcedState = FREE;
        tick(1);
        check("ifetch_pulse_width", {31'b0, ihit}, 32'd0);

        // Both sides requesting continuously against a zero-wait RAM.
        resetDut();
        autoRam = 1'b1;
        dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h40;
        hitKind.delete(); hitCyc.delete();
        tick(14);
        dREN = 1'b0; iREN = 1'b0;
        check("alt_hit_count_ge4", {31'b0, hitKind.size() >= 4}, 32'd1);
        if (hitKind.size() >= 4) begin
            check("alt_kind0", hitKind[0], 1);
            check("alt_kind1", hitKind[1], 2);
            check("alt_kind2", hitKind[2], 1);
            check("alt_kind3", hitKind[3], 2);
            for (int k = 1; k < 4; k++) check("alt_gap", hitCyc[k] - hitCyc[k-1], 3);
        end
        check("alt_dload", dload, 32'hA5A5_0100);
        check("alt_iload", iload, 32'hA5A5_0040);
        tick(3);

        // Write wins over a simultaneous read; dload keeps its previous value.
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        tick(1);
        check("wr_ramWEN",   {31'b0, ramWEN}, 32'd1);
        check("wr_ramREN",   {31'b0, ramREN}, 32'd0);
        check("wr_ramstore", ramstore, 32'hDEAD_BEEF);
        check("wr_ramaddr",  ramaddr, 32'h200);
        tick(1);
        check("wr_dhit",  {31'b0, dhit}, 32'd1);
        check("wr_dload", dload, 32'hA5A5_0100);
        dREN = 1'b0; dWEN = 1'b0;
        tick(2);

        // RAM stuck BUSY: watchdog faults after TO grant cycles.
        autoRam = 1'b0; forcedState = BUSY;
        resetDut();
        dREN = 1'b1; daddr = 32'h300;
        for (int k = 0; k < TO; k++) begin
            tick(1);
            check("to_ren_held",  {31'b0, ramREN}, 32'd1);
            check("to_fault_low", {31'b0, fault}, 32'd0);
        end
        tick(1);
        check("to_fault",   {31'b0, fault}, 32'd1);
        check("to_ren_off", {31'b0, ramREN}, 32'd0);
        tick(3);
        check("to_fault_sticky", {31'b0, fault}, 32'd1);
        check("to_no_dhit",      {31'b0, dhit}, 32'd0);
        dREN = 1'b0;
        resetDut();
        check("to_fault_cleared", {31'b0, fault}, 32'd0);

        // RAM ERROR during an instruction grant.
        forcedState = FREE;
        iREN = 1'b1; iaddr = 32'h8;
        tick(1);
        check("err_grant", {31'b0, ramREN}, 32'd1);
        forcedState = ERROR;
        tick(1);
        check("err_fault", {31'b0, fault}, 32'd1);
        check("err_ihit",  {31'b0, ihit}, 32'd0);
        iREN = 1'b0; forcedState = FREE; dREN = 1'b1;
        tick(3);
        check("err_no_grant", {31'b0, ramREN}, 32'd0);
        check("err_no_dhit",  {31'b0, dhit}, 32'd0);

        // Reset in the middle of a grant.
        resetDut();
        forcedState = BUSY; dREN = 1'b1; daddr = 32'h44;
        tick(1);
        check("mid_grant_ren", {31'b0, ramREN}, 32'd1);
        nRST = 1'b0;
        tick(1);
        check("mid_rst_ren",  {31'b0, ramREN}, 32'd0);
        check("mid_rst_dhit", {31'b0, dhit}, 32'd0);
        nRST = 1'b1; dREN = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port RAM arbiter for the single-cycle/pipelined MIPS core: shares one RAM port between the instruction-fetch requester and the data-memory requester (driven by the control unit's read/write enables). Owns the RAM handshake, wait-state sequencing, fair arbitration and a watchdog, and returns registered hit/load data to each requester. It sits between the datapath's request logic and the RAM model/controller.

## Interface
- TIMEOUT, 64: max cycles a grant may wait for RAM ACCESS before faulting (≥2).
- CLK  in  1  system clock, all state on rising edge.
- nRST  in  1  synchronous, active-low reset (sampled on CLK rising edge).
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  32 (word_t)  instruction address.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit (dREN & dWEN together: write wins).
- daddr  in  32 (word_t)  data address.
- dstore  in  32 (word_t)  write data.
- ihit  out  1  one-cycle pulse: iload valid.
- iload  out  32  fetched instruction (registered, holds until next ihit).
- dhit  out  1  one-cycle pulse: data op complete, dload valid for reads.
- dload  out  32  read data (registered, holds until next read dhit).
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramstate==ACCESS.
- ramstate  in  2 (ramstate_t)  FREE/BUSY/ACCESS/ERROR.
- fault  out  1  sticky: RAM ERROR or timeout seen; cleared only by reset.

## Operation
- States: IDLE, DGRANT, IGRANT, FAULT.
- IDLE: RAM outputs all 0. If ihit or dhit currently high, no grant this cycle (requester still holding its just-served request). Else: only data pending → DGRANT; only iREN → IGRANT; both → grant the side not granted last (last_grant flag, reset value = instr, so data wins first contention).
- DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. ramstate==ACCESS → dhit<=1, dload<=ramload if read, last_grant<=data, → IDLE.
- IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0. ACCESS → ihit<=1, iload<=ramload, last_grant<=instr, → IDLE.
- Requester drops its request while granted → IDLE, no hit, last_grant unchanged.
- ramstate==ERROR in a grant, or wait counter reaches TIMEOUT-1 without ACCESS → FAULT; fault<=1. FAULT: RAM outputs 0, no hits, stays until reset.
- Wait counter: clog2(TIMEOUT) bits, cleared on entering a grant, +1 each grant cycle without ACCESS, never wraps.
- ramstate BUSY/FREE in a grant: hold outputs, keep waiting.
- Reset: state=IDLE, ihit=dhit=0, iload=dload=0, fault=0, counter=0, last_grant=instr; RAM outputs 0.

## Timing
- Request at IDLE cycle n → grant state and RAM outputs at n+1 (RAM outputs are combinational from state and held inputs).
- ACCESS seen in cycle m → hit pulse and load register valid in cycle m+1; state IDLE at m+1.
- Zero-wait RAM: request n → hit n+2; next grant earliest n+3. Throughput one access per 3 cycles minimum.
- Hits are exactly one cycle wide; never both high in the same cycle.
- Reset mid-grant: next cycle RAM enables 0, no hit emitted.

## Structure
- cpu_types_pkg supplies word_t and ramstate_t; add arb_state_t (IDLE, DGRANT, IGRANT, FAULT) to it.
- Single module; optional sub-module wait_timer (counter + terminal flag) parameterized by TIMEOUT.

## Test plan
- Reset: nRST=0 two cycles with iREN=dREN=1 → all outputs 0, fault=0; after release first grant is DGRANT.
- iREN=1, iaddr=0x0000_0004, RAM ACCESS after 2 BUSY cycles with ramload=0x2408_0001 → ramREN=1, ramaddr=0x4 for 3 cycles, ihit pulse one cycle later, iload=0x2408_0001.
- Simultaneous dREN (daddr=0x100) and iREN held continuously, zero-wait RAM → grants alternate D,I,D,I; dhit/ihit every 3 cycles, never overlapping.
- dWEN=1, dREN=1, daddr=0x200, dstore=0xDEAD_BEEF → ramWEN=1, ramREN=0, ramstore=0xDEAD_BEEF; dhit pulse, dload unchanged.
- RAM stays BUSY with TIMEOUT=8 → fault rises after 8 grant cycles, no hit, RAM enables drop; stays until nRST=0.
- ramstate=ERROR during IGRANT → fault=1 next cycle; dREN asserted afterwards gets no grant.
